decode_stage: RTL and testbench

//  Pipelined, parametrised instruction-decode stage between fetch and execute.

---
 rtl/decode_stage_pkg.sv | 36 +++
 rtl/decode_stage_fields.sv | 45 ++++
 rtl/decode_stage.sv | 115 +++++++++++
 tb/tb_decode_stage.sv | 378 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_stage_pkg.sv
// Shared decode definitions: default widths, opcode map and payload sizing.
package decode_stage_pkg;

  localparam int DEF_WORD_SIZE     = 16;
  localparam int DEF_OPCODE_SIZE   = 4;
  localparam int DEF_REG_ADDR_SIZE = 3;
  localparam int DEF_IMM_OUT_WIDTH = 16;
  localparam int DEF_PC_WIDTH      = 8;

  // Opcode map shared with execute; NOT..SHR are contiguous ALU operations.
  typedef enum logic [3:0] {
    OP_NOP    = 4'h0,
    OP_NOT    = 4'h1,
    OP_AND    = 4'h2,
    OP_OR     = 4'h3,
    OP_XOR    = 4'h4,
    OP_ADD    = 4'h5,
    OP_SUB    = 4'h6,
    OP_COMP   = 4'h7,
    OP_SHL    = 4'h8,
    OP_SHR    = 4'h9,
    OP_LOAD   = 4'hA,
    OP_STORE  = 4'hB,
    OP_BRANCH = 4'hC,
    OP_JUMP   = 4'hD,
    OP_HALT   = 4'hE,
    OP_RSVD   = 4'hF
  } opcode_e;

  // Width of the packed {pc, opcode, dest, src, small_imm, big_imm, is_alu, illegal} payload.
  function automatic int decode_payload_width(input int pc_w, input int op_w,
                                              input int reg_w, input int imm_w);
    return pc_w + op_w + 2 * reg_w + 2 * imm_w + 2;
  endfunction

endpackage

// File: rtl/decode_stage_fields.sv
// Purely combinational split of an instruction word into decoded fields and extended immediates.
module decode_fields
  import decode_stage_pkg::*;
#(
  parameter int WORD_SIZE     = DEF_WORD_SIZE,
  parameter int OPCODE_SIZE   = DEF_OPCODE_SIZE,
  parameter int REG_ADDR_SIZE = DEF_REG_ADDR_SIZE,
  parameter int IMM_OUT_WIDTH = DEF_IMM_OUT_WIDTH,
  parameter int SIGN_EXTEND   = 1,
  parameter logic [2**OPCODE_SIZE-1:0] OPCODE_VALID_MASK = 16'h7FFF
) (
  input  logic [WORD_SIZE-1:0]     instr,
  output logic [OPCODE_SIZE-1:0]   opcode,
  output logic [REG_ADDR_SIZE-1:0] reg_dest,
  output logic [REG_ADDR_SIZE-1:0] reg_src,
  output logic [IMM_OUT_WIDTH-1:0] small_imm,
  output logic [IMM_OUT_WIDTH-1:0] big_imm,
  output logic                     is_alu,
  output logic                     illegal
);

  localparam int SMALL_IMM_SIZE = WORD_SIZE - OPCODE_SIZE - 2 * REG_ADDR_SIZE;
  localparam int BIG_IMM_SIZE   = REG_ADDR_SIZE + SMALL_IMM_SIZE;

  logic [SMALL_IMM_SIZE-1:0] small_field;
  logic [BIG_IMM_SIZE-1:0]   big_field;

  assign opcode      = instr[WORD_SIZE-1 -: OPCODE_SIZE];
  assign reg_dest    = instr[WORD_SIZE-OPCODE_SIZE-1 -: REG_ADDR_SIZE];
  assign reg_src     = instr[BIG_IMM_SIZE-1 -: REG_ADDR_SIZE];
  assign small_field = instr[SMALL_IMM_SIZE-1:0];
  assign big_field   = instr[BIG_IMM_SIZE-1:0];

  // A signed cast before widening replicates the field MSB; an unsigned one pads zeros.
  assign small_imm = (SIGN_EXTEND != 0) ? IMM_OUT_WIDTH'($signed(small_field))
                                        : IMM_OUT_WIDTH'(small_field);
  assign big_imm   = (SIGN_EXTEND != 0) ? IMM_OUT_WIDTH'($signed(big_field))
                                        : IMM_OUT_WIDTH'(big_field);

  assign is_alu  = opcode inside {OPCODE_SIZE'(OP_NOT), OPCODE_SIZE'(OP_AND), OPCODE_SIZE'(OP_OR),
                                  OPCODE_SIZE'(OP_XOR), OPCODE_SIZE'(OP_ADD), OPCODE_SIZE'(OP_SUB),
                                  OPCODE_SIZE'(OP_COMP), OPCODE_SIZE'(OP_SHL), OPCODE_SIZE'(OP_SHR)};
  assign illegal = ~OPCODE_VALID_MASK[opcode];

endmodule

// File: rtl/decode_stage.sv
// Decode pipeline stage: one output register plus one skid register, valid/ready on both sides.
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter int WORD_SIZE     = DEF_WORD_SIZE,
  parameter int OPCODE_SIZE   = DEF_OPCODE_SIZE,
  parameter int REG_ADDR_SIZE = DEF_REG_ADDR_SIZE,
  parameter int IMM_OUT_WIDTH = DEF_IMM_OUT_WIDTH,
  parameter int SIGN_EXTEND   = 1,
  parameter int PC_WIDTH      = DEF_PC_WIDTH,
  parameter logic [2**OPCODE_SIZE-1:0] OPCODE_VALID_MASK = 16'h7FFF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WORD_SIZE-1:0]     in_instr,
  input  logic [PC_WIDTH-1:0]      in_pc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [PC_WIDTH-1:0]      out_pc,
  output logic [OPCODE_SIZE-1:0]   out_opcode,
  output logic [REG_ADDR_SIZE-1:0] out_reg_dest,
  output logic [REG_ADDR_SIZE-1:0] out_reg_src,
  output logic [IMM_OUT_WIDTH-1:0] out_small_imm,
  output logic [IMM_OUT_WIDTH-1:0] out_big_imm,
  output logic                     out_is_alu,
  output logic                     out_illegal
);

  localparam int PAYLOAD_W = decode_payload_width(PC_WIDTH, OPCODE_SIZE, REG_ADDR_SIZE, IMM_OUT_WIDTH);

  logic [OPCODE_SIZE-1:0]   dec_opcode;
  logic [REG_ADDR_SIZE-1:0] dec_reg_dest;
  logic [REG_ADDR_SIZE-1:0] dec_reg_src;
  logic [IMM_OUT_WIDTH-1:0] dec_small_imm;
  logic [IMM_OUT_WIDTH-1:0] dec_big_imm;
  logic                     dec_is_alu;
  logic                     dec_illegal;

  logic [PAYLOAD_W-1:0] in_payload;
  logic [PAYLOAD_W-1:0] out_reg;
  logic [PAYLOAD_W-1:0] skid_reg;
  logic                 out_valid_reg;
  logic                 skid_valid_reg;
  logic                 in_ready_reg;
  logic                 accept;
  logic                 load_out;

  decode_fields #(
    .WORD_SIZE         (WORD_SIZE),
    .OPCODE_SIZE       (OPCODE_SIZE),
    .REG_ADDR_SIZE     (REG_ADDR_SIZE),
    .IMM_OUT_WIDTH     (IMM_OUT_WIDTH),
    .SIGN_EXTEND       (SIGN_EXTEND),
    .OPCODE_VALID_MASK (OPCODE_VALID_MASK)
  ) u_fields (
    .instr     (in_instr),
    .opcode    (dec_opcode),
    .reg_dest  (dec_reg_dest),
    .reg_src   (dec_reg_src),
    .small_imm (dec_small_imm),
    .big_imm   (dec_big_imm),
    .is_alu    (dec_is_alu),
    .illegal   (dec_illegal)
  );

  assign in_payload = {in_pc, dec_opcode, dec_reg_dest, dec_reg_src,
                       dec_small_imm, dec_big_imm, dec_is_alu, dec_illegal};

  assign accept   = in_valid & in_ready_reg;
  assign load_out = ~out_valid_reg | out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      out_reg        <= '0;
      skid_reg       <= '0;
      out_valid_reg  <= 1'b0;
      skid_valid_reg <= 1'b0;
      in_ready_reg   <= 1'b0;
    end else if (flush) begin
      out_valid_reg  <= 1'b0;
      skid_valid_reg <= 1'b0;
      in_ready_reg   <= 1'b1;
    end else if (load_out) begin
      // in_ready is low whenever the skid holds a word, so no accept can coincide with a skid drain.
      if (skid_valid_reg) begin
        out_reg        <= skid_reg;
        out_valid_reg  <= 1'b1;
        skid_valid_reg <= 1'b0;
      end else begin
        if (accept) begin
          out_reg <= in_payload;
        end
        out_valid_reg <= accept;
      end
      in_ready_reg <= 1'b1;
    end else begin
      if (accept) begin
        skid_reg       <= in_payload;
        skid_valid_reg <= 1'b1;
        in_ready_reg   <= 1'b0;
      end else begin
        in_ready_reg   <= ~skid_valid_reg;
      end
    end
  end

  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign {out_pc, out_opcode, out_reg_dest, out_reg_src,
          out_small_imm, out_big_imm, out_is_alu, out_illegal} = out_reg;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: sign- and zero-extending instances on shared inputs, queue-based model.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, out_ready;
  logic [15:0] in_instr;
  logic [7:0]  in_pc;

  logic        in_ready, out_valid, out_is_alu, out_illegal;
  logic [7:0]  out_pc;
  logic [3:0]  out_opcode;
  logic [2:0]  out_reg_dest, out_reg_src;
  logic [15:0] out_small_imm, out_big_imm;

  logic        in_ready_z, out_valid_z, out_is_alu_z, out_illegal_z;
  logic [7:0]  out_pc_z;
  logic [3:0]  out_opcode_z;
  logic [2:0]  out_reg_dest_z, out_reg_src_z;
  logic [15:0] out_small_imm_z, out_big_imm_z;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  decode_stage dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_opcode(out_opcode), .out_reg_dest(out_reg_dest),
    .out_reg_src(out_reg_src), .out_small_imm(out_small_imm), .out_big_imm(out_big_imm),
    .out_is_alu(out_is_alu), .out_illegal(out_illegal)
  );

  decode_stage #(.SIGN_EXTEND(0)) dut_z (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_z),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid_z), .out_ready(out_ready),
    .out_pc(out_pc_z), .out_opcode(out_opcode_z), .out_reg_dest(out_reg_dest_z),
    .out_reg_src(out_reg_src_z), .out_small_imm(out_small_imm_z), .out_big_imm(out_big_imm_z),
    .out_is_alu(out_is_alu_z), .out_illegal(out_illegal_z)
  );

  typedef struct packed {
    logic [7:0]  pc;
    logic [3:0]  op;
    logic [2:0]  rd;
    logic [2:0]  rs;
    logic [15:0] si;
    logic [15:0] bi;
    logic [15:0] si_z;
    logic [15:0] bi_z;
    logic        alu;
    logic        ill;
    logic        vz;
  } dec_t;

  dec_t exp_q[$];

  // Field layout: [15:12] opcode, [11:9] dest, [8:6] src, [5:0] small imm, [8:0] big imm.
  // ALU opcodes are 1..9; only opcode 15 is illegal under the default mask.
  function automatic dec_t ref_decode(input logic [7:0] pc, input logic [15:0] w);
    dec_t r;
    int wi, op, si, bi;
    wi = int'(w);
    op = wi / 4096;
    si = wi % 64;
    bi = wi % 512;
    r.pc   = pc;
    r.op   = 4'(op);
    r.rd   = 3'((wi / 512) % 8);
    r.rs   = 3'((wi / 64) % 8);
    r.si_z = 16'(si);
    r.bi_z = 16'(bi);
    r.si   = 16'((si >= 32) ? si - 64 + 65536 : si);
    r.bi   = 16'((bi >= 256) ? bi - 512 + 65536 : bi);
    r.alu  = (op >= 1 && op <= 9);
    r.ill  = (op == 15);
    r.vz   = 1'b1;
    return r;
  endfunction

  function automatic dec_t observe();
    return {out_pc, out_opcode, out_reg_dest, out_reg_src, out_small_imm, out_big_imm,
            out_small_imm_z, out_big_imm_z, out_is_alu, out_illegal, out_valid_z};
  endfunction

  function automatic logic all_zero();
    return ({out_pc, out_opcode, out_reg_dest, out_reg_src, out_small_imm, out_big_imm,
             out_is_alu, out_illegal, out_pc_z, out_opcode_z, out_reg_dest_z, out_reg_src_z,
             out_small_imm_z, out_big_imm_z, out_is_alu_z, out_illegal_z} === '0);
  endfunction

  // One clock: samples handshakes at negedge, updates the model, returns #1 after the next posedge.
  task automatic tick(output bit xfer, output bit acc, output dec_t obs, output dec_t exp,
                      output bit empty);
    @(negedge clk);
    obs   = observe();
    exp   = '0;
    empty = 1'b0;
    xfer  = out_valid && out_ready && !flush && !reset;
    acc   = in_valid && in_ready && !flush && !reset;
    if (flush || reset) exp_q.delete();
    if (xfer) begin
      if (exp_q.size() > 0) exp = exp_q.pop_front();
      else empty = 1'b1;
    end
    if (acc) exp_q.push_back(ref_decode(in_pc, in_instr));
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bit x, a, e;
    dec_t o, p;
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = '0; in_pc = '0;
    repeat (3) tick(x, a, o, p, e);
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0 || out_valid_z !== 1'b0 || !all_zero()) begin
      miscompares++;
      $display("FAIL reset_state: out_valid=%b in_ready=%b payload=%h want 0 0 0",
               out_valid, in_ready, observe());
    end
    reset = 1'b0;
    tick(x, a, o, p, e);
    vectors++;
    if (in_ready !== 1'b1 || in_ready_z !== 1'b1 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL post_reset_ready: in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_directed_add();
    bit x, a, e;
    dec_t o, p;
    dec_t want;
    want = {8'h10, 4'd5, 3'd2, 3'd5, 16'hFFFF, 16'hFF7F, 16'h003F, 16'h017F, 1'b1, 1'b0, 1'b1};
    out_ready = 1'b1; in_valid = 1'b1; in_instr = 16'h557F; in_pc = 8'h10;
    tick(x, a, o, p, e);
    in_valid = 1'b0;
    vectors++;
    if (out_valid !== 1'b1 || observe() !== want) begin
      miscompares++;
      $display("FAIL add_decode: valid=%b got %h want %h", out_valid, observe(), want);
    end
    tick(x, a, o, p, e);
    vectors++;
    if (!x || e || o !== p) begin
      miscompares++;
      $display("FAIL add_transfer: xfer=%b got %h want %h", x, o, p);
    end
  endtask

  task automatic test_back_to_back();
    bit x, a, e;
    dec_t o, p;
    int first = -1, last = -1, nx = 0, na = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_valid = (i < 8);
      in_instr = 16'($urandom);
      in_pc    = 8'(8'h20 + i);
      tick(x, a, o, p, e);
      if (a) na++;
      if (x) begin
        nx++;
        if (first < 0) first = i;
        last = i;
        vectors++;
        if (e || o !== p) begin
          miscompares++;
          $display("FAIL b2b_word[%0d]: got %h want %h", i, o, p);
        end
      end
    end
    in_valid = 1'b0;
    vectors++;
    if (na != 8 || nx != 8 || last - first != 7) begin
      miscompares++;
      $display("FAIL b2b_rate: accepts=%0d xfers=%0d span=%0d want 8 8 7", na, nx, last - first);
    end
  endtask

  task automatic test_stall();
    bit x, a, e;
    dec_t o, p;
    logic [15:0] w [3];
    int k = 0, nx = 0;
    for (int i = 0; i < 3; i++) w[i] = 16'($urandom);
    out_ready = 1'b0; in_valid = 1'b1;
    for (int c = 0; c < 4; c++) begin
      in_instr = w[k]; in_pc = 8'(8'h40 + k);
      tick(x, a, o, p, e);
      if (a) k++;
      if (c == 1) begin
        vectors++;
        if (in_ready !== 1'b0) begin
          miscompares++;
          $display("FAIL stall_ready_low: in_ready=%b want 0", in_ready);
        end
      end
    end
    vectors++;
    if (k != 2 || exp_q.size() != 2 || out_valid !== 1'b1 || observe() !== exp_q[0]) begin
      miscompares++;
      $display("FAIL stall_hold: accepted=%0d valid=%b got %h want %h", k, out_valid, observe(),
               (exp_q.size() > 0) ? exp_q[0] : dec_t'('0));
    end
    out_ready = 1'b1;
    for (int c = 0; c < 10 && nx < 3; c++) begin
      in_valid = (k < 3);
      in_instr = w[(k < 3) ? k : 2]; in_pc = 8'(8'h40 + k);
      tick(x, a, o, p, e);
      if (a) k++;
      if (x) begin
        nx++;
        vectors++;
        if (e || o !== p) begin
          miscompares++;
          $display("FAIL stall_release[%0d]: got %h want %h", nx, o, p);
        end
      end
    end
    in_valid = 1'b0;
    vectors++;
    if (nx != 3) begin
      miscompares++;
      $display("FAIL stall_count: delivered=%0d want 3", nx);
    end
  endtask

  task automatic test_illegal();
    bit x, a, e;
    dec_t o, p;
    int n_ill = 0, nx = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_valid = (i < 4);
      in_instr = {4'hF, 12'($urandom)};
      in_pc    = 8'(8'h60 + i);
      tick(x, a, o, p, e);
      if (x) begin
        nx++;
        if (o.ill === 1'b1 && o.alu === 1'b0) n_ill++;
        vectors++;
        if (e || o !== p) begin
          miscompares++;
          $display("FAIL illegal_word[%0d]: got %h want %h", i, o, p);
        end
      end
    end
    in_valid = 1'b0;
    vectors++;
    if (nx != 4 || n_ill != 4) begin
      miscompares++;
      $display("FAIL illegal_flags: delivered=%0d flagged=%0d want 4 4", nx, n_ill);
    end
  endtask

  task automatic test_flush();
    bit x, a, e;
    dec_t o, p;
    int k = 0;
    out_ready = 1'b0; in_valid = 1'b1;
    for (int c = 0; c < 6 && k < 2; c++) begin
      in_instr = 16'($urandom); in_pc = 8'(8'h80 + k);
      tick(x, a, o, p, e);
      if (a) k++;
    end
    flush = 1'b1; in_instr = 16'h5ABC; in_pc = 8'hEE;
    tick(x, a, o, p, e);
    flush = 1'b0; in_valid = 1'b0;
    vectors++;
    if (k != 2 || out_valid !== 1'b0 || out_valid_z !== 1'b0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL flush_state: filled=%0d out_valid=%b in_ready=%b want 2 0 1",
               k, out_valid, in_ready);
    end
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick(x, a, o, p, e);
      vectors++;
      if (x) begin
        miscompares++;
        $display("FAIL flush_leak[%0d]: got %h want no output", c, o);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit x, a, e;
    dec_t o, p;
    int k = 0, w = 0;
    out_ready = 1'b0; in_valid = 1'b1;
    for (int c = 0; c < 6 && k < 2; c++) begin
      in_instr = 16'($urandom); in_pc = 8'(8'hA0 + k);
      tick(x, a, o, p, e);
      if (a) k++;
    end
    reset = 1'b1;
    tick(x, a, o, p, e);
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0 || !all_zero()) begin
      miscompares++;
      $display("FAIL reset_mid_state: out_valid=%b in_ready=%b payload=%h want 0 0 0",
               out_valid, in_ready, observe());
    end
    reset = 1'b0; in_valid = 1'b0;
    while (in_ready !== 1'b1 && w < 4) begin
      tick(x, a, o, p, e);
      w++;
    end
    in_valid = 1'b1; in_instr = 16'h9E41; in_pc = 8'hB5;
    tick(x, a, o, p, e);
    in_valid = 1'b0; out_ready = 1'b1;
    tick(x, a, o, p, e);
    vectors++;
    if (!x || e || o !== p || o.pc !== 8'hB5) begin
      miscompares++;
      $display("FAIL reset_mid_resume: xfer=%b got %h want %h", x, o, p);
    end
  endtask

  task automatic test_random();
    bit x, a, e;
    dec_t o, p;
    for (int c = 0; c < 400; c++) begin
      in_valid  = ($urandom_range(3) != 0);
      out_ready = ($urandom_range(2) != 0);
      flush     = ($urandom_range(49) == 0);
      in_instr  = 16'($urandom);
      in_pc     = 8'(c);
      tick(x, a, o, p, e);
      if (x) begin
        vectors++;
        if (e || o !== p) begin
          miscompares++;
          $display("FAIL random[%0d]: got %h want %h", c, o, p);
        end
      end
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick(x, a, o, p, e);
      if (x) begin
        vectors++;
        if (e || o !== p) begin
          miscompares++;
          $display("FAIL random_drain[%0d]: got %h want %h", c, o, p);
        end
      end
    end
    vectors++;
    if (exp_q.size() != 0 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL random_lost: pending=%0d out_valid=%b want 0 0", exp_q.size(), out_valid);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed_add();
    test_back_to_back();
    test_stall();
    test_illegal();
    test_flush();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
